spi_master_arbiter: RTL

Sequencer and round-robin arbiter that shares one `Generic_MasterSPI` instance among `NumReq` requesters. Each requester posts a multi-word transaction with its own CPOL/CPHA/BitOrder/SPIMode settings. The block programs the master, streams transmit words into `SendData`, routes `ReceivedData` back to the owner and releases the bus once the master is idle. It sits between the per-peripheral drivers and the single SPI master.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_master_arbiter_if.sv | 25 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/spi_master_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer/arbiter.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArb   = 3'd1,
    StLoad  = 3'd2,
    StXfer  = 3'd3,
    StDrain = 3'd4
  } state_e;

  // Bit positions inside each requester's 4-bit cfg field.
  localparam int unsigned CFG_CPOL  = 0;
  localparam int unsigned CFG_CPHA  = 1;
  localparam int unsigned CFG_ORDER = 2;
  localparam int unsigned CFG_MODE  = 3;
  localparam int unsigned CfgW      = 4;

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Signal bundle between the arbiter and the shared Generic_MasterSPI instance.
interface spi_master_arbiter_if #(
  parameter int unsigned WordLen = 8
);
  logic               CPOL;
  logic               CPHA;
  logic               BitOrder;
  logic               SPIMode;
  logic               SPIGo;
  logic [WordLen-1:0] SendData;
  logic               TxBusy;
  logic               RxBusy;
  logic               WordFlg;
  logic [WordLen-1:0] ReceivedData;

  modport master (
    output CPOL, CPHA, BitOrder, SPIMode, SPIGo, SendData,
    input  TxBusy, RxBusy, WordFlg, ReceivedData
  );

  modport slave (
    input  CPOL, CPHA, BitOrder, SPIMode, SPIGo, SendData,
    output TxBusy, RxBusy, WordFlg, ReceivedData
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request after 'last', wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              valid
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    // Offsets 1..NumReq visit last+1 first and last itself at the very end.
    for (int unsigned k = 1; k <= NumReq; k++) begin
      idx = (32'(last) + k) % NumReq;
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master among NumReq requesters: arbitrates, programs the
// master, streams words in and routes received words back to the owner.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned WordLen    = 8,
  parameter int unsigned LenW       = 4,
  parameter int unsigned TimeoutCyc = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumReq-1:0]         req,
  input  logic [CfgW*NumReq-1:0]    cfg,
  input  logic [LenW*NumReq-1:0]    len,
  input  logic [WordLen*NumReq-1:0] tx_data,
  output logic [NumReq-1:0]         tx_pop,
  output logic [WordLen-1:0]        rx_data,
  output logic [NumReq-1:0]         rx_valid,
  output logic [NumReq-1:0]         grant,
  output logic [NumReq-1:0]         done,
  output logic [NumReq-1:0]         err,
  spi_master_arbiter_if.master      spi
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned WdW  = $clog2(TimeoutCyc + 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic [LenW-1:0]     remaining_q, remaining_d;
  logic [WdW-1:0]      wdog_q, wdog_d;
  logic [CfgW-1:0]     cfg_q, cfg_d;
  logic [WordLen-1:0]  send_q, send_d;
  logic                go_q, go_d;
  logic [WordLen-1:0]  rxd_q, rxd_d;
  logic [NumReq-1:0]   tx_pop_q, tx_pop_d;
  logic [NumReq-1:0]   rx_valid_q, rx_valid_d;
  logic [NumReq-1:0]   done_q, done_d;
  logic [NumReq-1:0]   err_q, err_d;
  logic                abort_q, abort_d;

  logic [NumReq-1:0]   pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic                busy;
  logic [WordLen-1:0]  owner_word;

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr (
    .req     (req),
    .last    (last_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign busy       = spi.TxBusy | spi.RxBusy;
  assign owner_word = tx_data[owner_q*WordLen +: WordLen];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    wdog_d      = wdog_q;
    cfg_d       = cfg_q;
    send_d      = send_q;
    go_d        = go_q;
    rxd_d       = rxd_q;
    abort_d     = abort_q;
    tx_pop_d    = '0;
    rx_valid_d  = '0;
    done_d      = '0;
    err_d       = '0;

    case (state_q)
      StIdle: begin
        if ((|req) && !busy) begin
          state_d = StArb;
        end
      end

      StArb: begin
        if (pick_valid) begin
          grant_d     = pick_gnt;
          owner_d     = pick_idx;
          last_d      = pick_idx;
          cfg_d       = cfg[pick_idx*CfgW +: CfgW];
          remaining_d = len[pick_idx*LenW +: LenW];
          state_d     = StLoad;
        end else begin
          // Request withdrawn before arbitration; nothing to serve.
          state_d = StIdle;
        end
      end

      StLoad: begin
        send_d   = owner_word;
        tx_pop_d = grant_q;
        go_d     = 1'b1;
        wdog_d   = '0;
        abort_d  = 1'b0;
        state_d  = StXfer;
      end

      StXfer: begin
        if (spi.WordFlg) begin
          rxd_d      = spi.ReceivedData;
          rx_valid_d = grant_q;
          wdog_d     = '0;
          if (remaining_q == '0) begin
            go_d    = 1'b0;
            state_d = StDrain;
          end else begin
            remaining_d = remaining_q - LenW'(1);
            send_d      = owner_word;
            tx_pop_d    = grant_q;
          end
        end else if (wdog_q == WdW'(TimeoutCyc - 1)) begin
          go_d    = 1'b0;
          err_d   = grant_q;
          abort_d = 1'b1;
          state_d = StDrain;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end

      StDrain: begin
        if (!busy) begin
          // An aborted transaction already reported err; no done for it.
          if (!abort_q) begin
            done_d = grant_q;
          end
          grant_d = '0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(NumReq - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      remaining_q <= '0;
      wdog_q      <= '0;
      cfg_q       <= '0;
      send_q      <= '0;
      go_q        <= 1'b0;
      rxd_q       <= '0;
      abort_q     <= 1'b0;
      tx_pop_q    <= '0;
      rx_valid_q  <= '0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      remaining_q <= remaining_d;
      wdog_q      <= wdog_d;
      cfg_q       <= cfg_d;
      send_q      <= send_d;
      go_q        <= go_d;
      rxd_q       <= rxd_d;
      abort_q     <= abort_d;
      tx_pop_q    <= tx_pop_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign tx_pop       = tx_pop_q;
  assign rx_data      = rxd_q;
  assign rx_valid     = rx_valid_q;
  assign grant        = grant_q;
  assign done         = done_q;
  assign err          = err_q;
  assign spi.CPOL     = cfg_q[CFG_CPOL];
  assign spi.CPHA     = cfg_q[CFG_CPHA];
  assign spi.BitOrder = cfg_q[CFG_ORDER];
  assign spi.SPIMode  = cfg_q[CFG_MODE];
  assign spi.SPIGo    = go_q;
  assign spi.SendData = send_q;

endmodule
